// File: rtl/panel_pkg.sv
// Shared types and helpers for the front-panel scanner.
//   phase_t : scan phase of the row multiplexer
//   cnt_w   : bit width needed to count 0..n-1 (never less than 1)
package panel_pkg;

    typedef enum logic [1:0] {
        LED_BLANK = 2'd0,
        LED_DRIVE = 2'd1,
        SW_BLANK  = 2'd2,
        SW_SETTLE = 2'd3
    } phase_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/panel_scanner_if.sv
// Panel-side bundle of the scanner: indicator/switch data toward the core
// and the multiplexed row/column pins toward the top-level I/O.
//   master : the scanner (drives rows, columns, sw_state, strobes)
//   slave  : the environment (drives led_data, lamp_test, col_in)
interface panel_scanner_if #(
    parameter int COLS     = 12,
    parameter int LED_ROWS = 8,
    parameter int SW_ROWS  = 3
);
    logic [LED_ROWS*COLS-1:0] led_data;
    logic                     lamp_test;
    logic [LED_ROWS-1:0]      led_row;
    logic [SW_ROWS-1:0]       sw_row;
    logic [COLS-1:0]          col_out;
    logic                     col_oe;
    logic [COLS-1:0]          col_in;
    logic [SW_ROWS*COLS-1:0]  sw_state;
    logic                     frame_done;
    logic                     sw_changed;

    modport master (
        input  led_data, lamp_test, col_in,
        output led_row, sw_row, col_out, col_oe, sw_state, frame_done, sw_changed
    );

    modport slave (
        output led_data, lamp_test, col_in,
        input  led_row, sw_row, col_out, col_oe, sw_state, frame_done, sw_changed
    );
endinterface

// File: rtl/panel_debounce.sv
// Vectorised multi-frame switch debounce.
//   clk, rst : clock, synchronous active-high reset
//   raw      : switch sample for the frame just completed
//   strobe   : one-cycle frame-end strobe; raw is only looked at here
//   state    : debounced value, updates the cycle after strobe
//   changed  : registered pulse coincident with any state update
// A bit flips once raw has disagreed with state on DEB_FRAMES consecutive
// strobes; any agreeing strobe restarts the count.
module panel_debounce
    import panel_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int DEB_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    input  logic             strobe,
    output logic [WIDTH-1:0] state,
    output logic             changed
);
    localparam int DW = cnt_w(DEB_FRAMES + 1);
    // count value at which the next disagreeing frame completes the run
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_FRAMES - 1);

    logic [WIDTH-1:0][DW-1:0] cnt;
    logic [WIDTH-1:0]         flip;

    always_comb begin
        flip = '0;
        for (int b = 0; b < WIDTH; b++)
            flip[b] = strobe && (raw[b] != state[b]) && (cnt[b] == DEB_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            state   <= '0;
            changed <= 1'b0;
        end else begin
            changed <= |flip;
            if (strobe) begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (raw[b] == state[b]) begin
                        cnt[b] <= '0;
                    end else if (flip[b]) begin
                        cnt[b]   <= '0;
                        state[b] <= ~state[b];
                    end else begin
                        cnt[b] <= cnt[b] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/panel_scanner.sv
// Front-panel scanner: time-multiplexes LED rows and switch rows over one
// shared column bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : panel_scanner_if master (led_data/lamp_test/col_in in;
//              led_row/sw_row/col_out/col_oe/sw_state/frame_done/sw_changed out)
// Frame: per LED row BLANK then DRIVE, then per switch row BLANK then SETTLE.
// Column pins sink current, so a lit LED is a 0 on col_out. Pin outputs are
// a decode of the registered phase/row so rows never overlap.
module panel_scanner
    import panel_pkg::*;
#(
    parameter int COLS       = 12,
    parameter int LED_ROWS   = 8,
    parameter int SW_ROWS    = 3,
    parameter int BLANK_CYC  = 16,
    parameter int DWELL_CYC  = 4096,
    parameter int SETTLE_CYC = 256,
    parameter int DEB_FRAMES = 4
) (
    input  logic            clk,
    input  logic            rst,
    panel_scanner_if.master bus
);
    localparam int MAX_BD  = (BLANK_CYC > DWELL_CYC) ? BLANK_CYC : DWELL_CYC;
    localparam int MAX_CYC = (MAX_BD > SETTLE_CYC) ? MAX_BD : SETTLE_CYC;
    localparam int CW      = cnt_w(MAX_CYC);
    localparam int RW      = cnt_w((LED_ROWS > SW_ROWS) ? LED_ROWS : SW_ROWS);

    localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [RW-1:0] LED_LAST    = RW'(LED_ROWS - 1);
    localparam logic [RW-1:0] SW_LAST     = RW'(SW_ROWS - 1);

    phase_t          phase, phase_nx;
    logic [RW-1:0]   row, row_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            phase_end;

    logic [LED_ROWS-1:0][COLS-1:0] snap;
    logic [COLS-1:0]               snap_row;
    logic                          lamp_lat;
    logic                          lamp_on;

    logic [SW_ROWS-1:0][COLS-1:0]  raw;
    logic [SW_ROWS-1:0][COLS-1:0]  raw_frame;
    logic                          sample;
    logic                          frame_end;

    logic [SW_ROWS*COLS-1:0]       sw_state_q;
    logic                          sw_chg_q;

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= LED_BLANK;
            row   <= '0;
            cnt   <= '0;
        end else begin
            phase <= phase_nx;
            row   <= row_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        phase_nx  = phase;
        row_nx    = row;
        cnt_nx    = cnt + 1'b1;
        phase_end = 1'b0;
        case (phase)
            LED_BLANK, SW_BLANK: phase_end = (cnt == BLANK_LAST);
            LED_DRIVE:           phase_end = (cnt == DWELL_LAST);
            SW_SETTLE:           phase_end = (cnt == SETTLE_LAST);
            default:             phase_end = 1'b1;
        endcase
        if (phase_end) begin
            cnt_nx = '0;
            case (phase)
                LED_BLANK: phase_nx = LED_DRIVE;
                LED_DRIVE: begin
                    if (row == LED_LAST) begin
                        row_nx   = '0;
                        phase_nx = SW_BLANK;
                    end else begin
                        row_nx   = row + 1'b1;
                        phase_nx = LED_BLANK;
                    end
                end
                SW_BLANK:  phase_nx = SW_SETTLE;
                SW_SETTLE: begin
                    if (row == SW_LAST) begin
                        row_nx   = '0;
                        phase_nx = LED_BLANK;
                    end else begin
                        row_nx   = row + 1'b1;
                        phase_nx = SW_BLANK;
                    end
                end
                default: begin
                    row_nx   = '0;
                    phase_nx = LED_BLANK;
                end
            endcase
        end
    end

    // ---------------- datapath ----------------
    assign sample    = (phase == SW_SETTLE) && phase_end;
    assign frame_end = sample && (row == SW_LAST);

    // Raw image including the row being sampled this cycle, so the debounce
    // sees the complete frame on the frame-end strobe.
    always_comb begin
        raw_frame = raw;
        for (int s = 0; s < SW_ROWS; s++)
            if (sample && row == RW'(s))
                raw_frame[s] = bus.col_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap     <= '0;
            lamp_lat <= 1'b0;
            raw      <= '0;
        end else begin
            // frame-coherent copy taken on the very first cycle of the frame
            if (phase == LED_BLANK && row == '0 && cnt == '0)
                snap <= bus.led_data;
            if (phase == LED_DRIVE && cnt == '0)
                lamp_lat <= bus.lamp_test;
            if (sample)
                raw <= raw_frame;
        end
    end

    always_comb begin
        snap_row = '0;
        for (int i = 0; i < LED_ROWS; i++)
            if (row == RW'(i))
                snap_row = snap[i];
    end

    // lamp_test is taken on the first drive cycle and held for the phase
    assign lamp_on = (cnt == '0) ? bus.lamp_test : lamp_lat;

    // ---------------- pin decode ----------------
    always_comb begin
        bus.led_row = '0;
        bus.sw_row  = '0;
        bus.col_oe  = 1'b0;
        bus.col_out = '1;
        case (phase)
            LED_DRIVE: begin
                for (int i = 0; i < LED_ROWS; i++)
                    bus.led_row[i] = (row == RW'(i));
                bus.col_oe  = 1'b1;
                bus.col_out = lamp_on ? '0 : ~snap_row;
            end
            SW_SETTLE: begin
                for (int s = 0; s < SW_ROWS; s++)
                    bus.sw_row[s] = (row == RW'(s));
            end
            default: ;
        endcase
    end

    assign bus.frame_done = frame_end;

    panel_debounce #(
        .WIDTH     (SW_ROWS * COLS),
        .DEB_FRAMES(DEB_FRAMES)
    ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw_frame),
        .strobe (frame_end),
        .state  (sw_state_q),
        .changed(sw_chg_q)
    );

    assign bus.sw_state   = sw_state_q;
    assign bus.sw_changed = sw_chg_q;
endmodule
